// File: rtl/sd_resp_rx_if.sv
// sd_resp_rx_if
//   Bundles the SD CMD-line response receiver's control, serial input and
//   result signals so that the host FSM and the receiver connect as one port.
//   master : host side.   Drives start/long_resp/no_crc and the pad's cmd_in;
//            observes busy/done and the status and response fields.
//   slave  : receiver side (sd_resp_rx).
//   Signals:
//     start      arm pulse, one cycle
//     long_resp  1 = 136-bit R2 frame, 0 = 48-bit frame (sampled with start)
//     no_crc     1 = skip the CRC check (sampled with start)
//     cmd_in     serial CMD line, idle high
//     busy       armed/receiving, through the done cycle
//     done       one-cycle completion pulse
//     timeout    no start bit seen within NCR_MAX cycles
//     crc_ok     computed CRC7 equals the received CRC field
//     frame_err  bad transmission bit or bad end bit
//     resp_data  response payload, right-aligned
//     resp_crc   received CRC7 field
interface sd_resp_rx_if;
    logic         start;
    logic         long_resp;
    logic         no_crc;
    logic         cmd_in;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         crc_ok;
    logic         frame_err;
    logic [119:0] resp_data;
    logic [6:0]   resp_crc;

    modport master (
        output start, long_resp, no_crc, cmd_in,
        input  busy, done, timeout, crc_ok, frame_err, resp_data, resp_crc
    );

    modport slave (
        input  start, long_resp, no_crc, cmd_in,
        output busy, done, timeout, crc_ok, frame_err, resp_data, resp_crc
    );
endinterface

// File: rtl/sd_resp_rx.sv
// sd_resp_rx
//   Receive side of the SD CMD line. Deserialises a 48-bit (R1/R3/R6/R7) or
//   136-bit (R2) response, one bit per clk, MSB first, and checks it with a
//   serial CRC7 (x^7 + x^3 + 1) computed on the fly.
//   Ports:
//     clk    clock; cmd_in sampled on the rising edge
//     reset  asynchronous, active low
//     bus    sd_resp_rx_if.slave -- arm/config inputs, serial line, status
//            and response outputs (see the interface file)
//   Parameter:
//     NCR_MAX  idle-high cycles allowed between arm and start bit
module sd_resp_rx #(
    parameter int NCR_MAX = 64
) (
    input  logic        clk,
    input  logic        reset,
    sd_resp_rx_if.slave bus
);

    localparam int WW = $clog2(NCR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECV,
        DONE
    } state_t;

    state_t         state;
    logic [WW-1:0]  wait_cnt;
    logic [7:0]     bit_cnt;
    logic [6:0]     crc;
    logic           long_q;
    logic           no_crc_q;

    logic           busy_q;
    logic           done_q;
    logic           timeout_q;
    logic           crc_ok_q;
    logic           frame_err_q;
    logic [119:0]   data_q;
    logic [6:0]     rcrc_q;

    // Frame layout, as received-bit index (0 = start bit).
    logic [7:0]     last_idx;
    logic [7:0]     data_lo;
    logic [7:0]     data_hi;
    logic           in_data;
    logic           in_crc;
    logic           crc_fb;
    logic [6:0]     crc_nxt;
    logic [WW-1:0]  wait_nxt;

    always_comb begin
        last_idx = long_q ? 8'd135 : 8'd47;
        data_lo  = long_q ? 8'd8   : 8'd0;
        data_hi  = long_q ? 8'd127 : 8'd39;
        in_data  = (bit_cnt >= data_lo) && (bit_cnt <= data_hi);
        in_crc   = (bit_cnt > data_hi) && (bit_cnt < last_idx);
        crc_fb   = crc[6] ^ bus.cmd_in;
        crc_nxt  = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
        wait_nxt = wait_cnt + WW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            bit_cnt     <= '0;
            crc         <= '0;
            long_q      <= 1'b0;
            no_crc_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            crc_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
            rcrc_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // busy_q is still high during the done cycle, so a start
                    // arriving alongside the done pulse is ignored.
                    if (bus.start && !busy_q) begin
                        long_q      <= bus.long_resp;
                        no_crc_q    <= bus.no_crc;
                        data_q      <= '0;
                        rcrc_q      <= '0;
                        timeout_q   <= 1'b0;
                        crc_ok_q    <= 1'b0;
                        frame_err_q <= 1'b0;
                        wait_cnt    <= '0;
                        bit_cnt     <= '0;
                        crc         <= '0;
                        busy_q      <= 1'b1;
                        state       <= WAIT_START;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                WAIT_START: begin
                    if (!bus.cmd_in) begin
                        // The start bit is 0: shifting it into the cleared
                        // data and CRC registers changes neither, so it is
                        // simply consumed here.
                        bit_cnt <= 8'd1;
                        crc     <= '0;
                        state   <= RECV;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (wait_nxt == WW'(NCR_MAX)) begin
                            timeout_q <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                RECV: begin
                    bit_cnt <= bit_cnt + 8'd1;
                    if (bit_cnt == 8'd1 && bus.cmd_in) begin
                        frame_err_q <= 1'b1;
                    end
                    if (in_data) begin
                        data_q <= {data_q[118:0], bus.cmd_in};
                        crc    <= crc_nxt;
                    end
                    if (in_crc) begin
                        rcrc_q <= {rcrc_q[5:0], bus.cmd_in};
                    end
                    if (bit_cnt == last_idx) begin
                        if (!bus.cmd_in) begin
                            frame_err_q <= 1'b1;
                        end
                        state <= DONE;
                    end
                end

                DONE: begin
                    done_q   <= 1'b1;
                    crc_ok_q <= !timeout_q && (no_crc_q || (crc == rcrc_q));
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.resp_data = data_q;
    assign bus.resp_crc  = rcrc_q;

endmodule
